// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg: shared state type and width helper for the SIPO receive controller
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2
    } rx_state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_gap_timer.sv
// sipo_gap_timer: counts idle SHIFT cycles between bit strobes and flags the TIMEOUT-th one
module sipo_gap_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expired
);

    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt;

    // idle-cycle counter, held at zero outside the frame and on any strobe
    always_ff @(posedge clk) begin
        if (rst || !enable || restart)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // the current idle cycle is the TIMEOUT-th in a row; zero TIMEOUT never fires
    assign expired = (TIMEOUT != 0) && enable && !restart && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: frames bit strobes into the external SIPO and hands words out on valid/ready
module sipo_rx_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      bit_valid,
    output logic                      shift_en,
    input  logic [WIDTH-1:0]          sipo_data,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      frame_err,
    output logic                      overrun,
    input  logic                      err_clr
);

    localparam int BW = cnt_w(WIDTH);

    rx_state_e state, state_next;
    logic      expired;
    logic      last_bit;
    logic      capture;
    logic      free;

    assign last_bit = (state == SHIFT) && bit_valid && (bit_cnt == BW'(WIDTH - 1));
    assign capture  = (state == CAPTURE);
    assign free     = !out_valid || out_ready;

    sipo_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == SHIFT),
        .restart (bit_valid || frame_start),
        .expired (expired)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // frame_start always (re)enters SHIFT, even from CAPTURE and mid-frame
    always_comb begin
        state_next = frame_start                    ? SHIFT   :
                     last_bit                       ? CAPTURE :
                     (state == SHIFT && !expired)   ? SHIFT   : IDLE;
    end

    // SIPO shifts only on strobes that belong to a frame; never during CAPTURE
    always_comb begin
        shift_en = (state == IDLE)  ? frame_start & bit_valid :
                   (state == SHIFT) ? bit_valid               : 1'b0;
        busy     = (state != IDLE);
    end

    // bits shifted so far; a frame_start in CAPTURE restarts at 0 because nothing shifts
    always_ff @(posedge clk) begin
        if (rst)
            bit_cnt <= '0;
        else
            bit_cnt <= (frame_start && !capture)        ? BW'(bit_valid) :
                       (state == SHIFT && bit_valid)    ? bit_cnt + BW'(1) :
                       (state == SHIFT && !expired)     ? bit_cnt :
                                                          '0;
    end

    // holding register, handshake, and error flags; overrun set wins over err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= expired;
            overrun   <= (capture && !free) || (overrun && !err_clr);
            if (capture && free) begin
                out_data  <= sipo_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
